branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor that produces the 1-bit `prediction` consumed by the branch-resolution/correction stage downstream.
- Produces the predicted target for the PC mux.
- Direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB), both indexed by PC.
- Trained by the execute stage once each conditional branch (opcode 1100011) resolves; keeps saturating branch/mispredict statistics.

Parameters:
- IDX_W, 6, index width; table depth = 2^IDX_W entries
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken)
- STAT_W, 16, width of statistics counters

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- lk_en  input  1  lookup enable; 0 = fetch stall, registered outputs hold
- lk_pc  input  32  PC of instruction being fetched
- prediction  output  1  registered: 1 = predict taken
- pred_target  output  32  registered predicted target (valid when prediction=1)
- pred_hit  output  1  registered BTB tag hit for looked-up PC
- upd_en  input  1  execute stage resolved a conditional branch this cycle
- upd_pc  input  32  PC of resolved branch
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual taken target
- upd_mispred  input  1  resolved outcome/target differed from prediction carried down the pipe
- cnt_branches  output  STAT_W  resolved branch count
- cnt_mispred  output  STAT_W  mispredict count

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] are ignored.
- Storage per entry:
  - ctr[1:0]
  - valid
  - tag[31-IDX_W-2:0]
  - target[31:0]
- Reset (rst_n=0, asynchronous, any time including mid-update):
  - all ctr = CNT_INIT; all valid = 0
  - prediction = 0, pred_hit = 0, pred_target = 0
  - cnt_branches = 0, cnt_mispred = 0
  - Tag/target contents need not be cleared.
- Lookup (1-cycle latency): on a rising edge with lk_en=1, register:
  - pred_hit = valid[idx] & (tag[idx]==lk_pc tag)
  - prediction = pred_hit & ctr[idx][1]
  - pred_target = pred_hit ? target[idx] : lk_pc+4
- With lk_en=0, all three lookup outputs hold their value.
- Update, on a rising edge with upd_en=1:
  - Counter: upd_taken ? (ctr==3 ? 3 : ctr+1) : (ctr==0 ? 0 : ctr-1). Saturating, no wrap.
  - If upd_taken=1: valid=1, tag and target written from upd_pc/upd_target. Overwrites an aliasing entry, and its counter update still applies to the shared ctr.
  - If upd_taken=0: BTB fields are unchanged.
- Simultaneous lookup and update to the same index in one cycle is write-first:
  - the registered lookup result uses the post-update ctr/valid/tag/target values.
- Different indices update and look up independently.
- Statistics:
  - If upd_en=1, cnt_branches increments.
  - If upd_en=1 and upd_mispred=1, cnt_mispred increments.
  - Both saturate at all-ones.
  - upd_mispred is ignored when upd_en=0.
- Inputs are sampled only on the clock edge; there is no combinational path from any input to any output.
- Non-branch instructions (JAL/JALR) never call update; the downstream stage handles them.

Test Plan:
1. Reset, then lk_en=1, lk_pc=0x100 → next cycle prediction=0, pred_hit=0, pred_target=0x104.
2. Train index: upd_en on pc=0x100, taken, target 0x200, 1 cycle → ctr 01→10. Then lookup 0x100 → pred_hit=1, prediction=1, pred_target=0x200.
3. Saturation: 4 taken updates → ctr stays 3. Then 1 not-taken → 2, prediction still 1. Then second not-taken → 1, prediction 0.
4. Aliasing: train pc=0x100 taken, then look up pc=0x100+(4<<IDX_W) → pred_hit=0, prediction=0. Update the alias taken with target 0x300 → original pc now misses.
5. Same-cycle update (not-taken, ctr 2→1) and lookup at same pc → registered prediction=0 (write-first). With lk_en=0 the following cycle, outputs hold.
6. Statistics: 3 updates with upd_mispred=1,0,1 → cnt_branches=3, cnt_mispred=2. Assert rst_n low mid-sequence → counters 0 and prediction 0 immediately, without a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage dynamic branch predictor. A direct-mapped table of
//               2-bit saturating counters shares its index with a tagged
//               branch target buffer. Lookups are registered (1-cycle latency);
//               the execute stage trains the table when a conditional branch
//               resolves. Saturating branch/mispredict statistics are kept.
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               lk_en, lk_pc          lookup request (lk_en=0 holds outputs)
//               prediction            registered taken prediction
//               pred_target           registered predicted next PC
//               pred_hit              registered BTB tag hit
//               upd_en, upd_pc,       resolved-branch training interface
//               upd_taken, upd_target,
//               upd_mispred
//               cnt_branches          saturating resolved-branch count
//               cnt_mispred           saturating mispredict count
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  CNT_INIT = 2'b01,
    parameter int          STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_en,
    input  logic [31:0]       lk_pc,
    output logic              prediction,
    output logic [31:0]       pred_target,
    output logic              pred_hit,
    input  logic              upd_en,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_mispred,
    output logic [STAT_W-1:0] cnt_branches,
    output logic [STAT_W-1:0] cnt_mispred
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    // Table storage
    logic [1:0]       ctr_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];

    // Registered outputs and statistics
    logic              prediction_q,   prediction_d;
    logic              pred_hit_q,     pred_hit_d;
    logic [31:0]       pred_target_q,  pred_target_d;
    logic [STAT_W-1:0] cnt_branches_q, cnt_branches_d;
    logic [STAT_W-1:0] cnt_mispred_q,  cnt_mispred_d;

    // Combinational helpers
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [1:0]       ctr_upd_d;
    logic             fwd_ctr;
    logic             fwd_btb;
    logic [1:0]       lk_ctr;
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag_rd;
    logic [31:0]      lk_target_rd;
    logic             lk_hit;

    // Byte-offset bits of the update PC carry no information for the table.
    logic unused_upd_pc_lsb;
    assign unused_upd_pc_lsb = ^upd_pc[1:0];

    always_comb begin
        upd_idx = upd_pc[IDX_W+1:2];
        upd_tag = upd_pc[31:IDX_W+2];
        lk_idx  = lk_pc[IDX_W+1:2];
        lk_tag  = lk_pc[31:IDX_W+2];

        // Saturating 2-bit counter step for the entry being trained
        ctr_upd_d = ctr_q[upd_idx];
        if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'd3) ctr_upd_d = ctr_q[upd_idx] + 2'd1;
        end else begin
            if (ctr_q[upd_idx] != 2'd0) ctr_upd_d = ctr_q[upd_idx] - 2'd1;
        end

        // Write-first bypass: a lookup hitting the index being trained this
        // cycle sees the post-update counter and, for taken updates, the
        // freshly written BTB fields.
        fwd_ctr      = upd_en && (upd_idx == lk_idx);
        fwd_btb      = fwd_ctr && upd_taken;
        lk_ctr       = fwd_ctr ? ctr_upd_d  : ctr_q[lk_idx];
        lk_valid     = fwd_btb ? 1'b1       : valid_q[lk_idx];
        lk_tag_rd    = fwd_btb ? upd_tag    : tag_q[lk_idx];
        lk_target_rd = fwd_btb ? upd_target : target_q[lk_idx];
        lk_hit       = lk_valid && (lk_tag_rd == lk_tag);

        prediction_d  = prediction_q;
        pred_hit_d    = pred_hit_q;
        pred_target_d = pred_target_q;
        if (lk_en) begin
            pred_hit_d    = lk_hit;
            prediction_d  = lk_hit && lk_ctr[1];
            pred_target_d = lk_hit ? lk_target_rd : (lk_pc + 32'd4);
        end

        cnt_branches_d = cnt_branches_q;
        cnt_mispred_d  = cnt_mispred_q;
        if (upd_en) begin
            if (!(&cnt_branches_q)) cnt_branches_d = cnt_branches_q + 1'b1;
            if (upd_mispred && !(&cnt_mispred_q)) cnt_mispred_d = cnt_mispred_q + 1'b1;
        end
    end

    // Counters, valid bits, outputs and statistics: asynchronously reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CNT_INIT;
            end
            valid_q        <= '0;
            prediction_q   <= 1'b0;
            pred_hit_q     <= 1'b0;
            pred_target_q  <= '0;
            cnt_branches_q <= '0;
            cnt_mispred_q  <= '0;
        end else begin
            if (upd_en) begin
                ctr_q[upd_idx] <= ctr_upd_d;
                if (upd_taken) valid_q[upd_idx] <= 1'b1;
            end
            prediction_q   <= prediction_d;
            pred_hit_q     <= pred_hit_d;
            pred_target_q  <= pred_target_d;
            cnt_branches_q <= cnt_branches_d;
            cnt_mispred_q  <= cnt_mispred_d;
        end
    end

    // Tag/target payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    assign prediction   = prediction_q;
    assign pred_hit     = pred_hit_q;
    assign pred_target  = pred_target_q;
    assign cnt_branches = cnt_branches_q;
    assign cnt_mispred  = cnt_mispred_q;

endmodule
`default_nettype wire
